// File: rtl/response_encoder.sv
// Turns bus completions into ASCII replies on an AXI-Stream byte master.
// Reads produce uppercase hex digits and NL_CHAR. Define RESP_WRITE_ACK_EN to also answer writes with "OK" and NL_CHAR.
//
// state | meaning
// IDLE  | waiting for a completion; tvalid low
// HEX   | streaming hex digits of the captured word, MS nibble first
// OK_O  | presenting 'O' of a write acknowledge
// OK_K  | presenting 'K' of a write acknowledge
// NL    | presenting the line terminator; returns to IDLE on handshake
module response_encoder #(
  parameter int         DATA_W  = 32,
  parameter logic [7:0] NL_CHAR = 8'h0A
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Cs,
  input  logic              We,
  input  logic              Ack,
  input  logic [DATA_W-1:0] Rdata,
  output logic              M_axis_tvalid,
  output logic [7:0]        M_axis_tdata,
  input  logic              M_axis_tready,
  output logic              Busy,
  output logic              Overrun,
  input  logic              Overrun_clr
);

  localparam int N_DIGITS = DATA_W / 4;
  localparam int CNT_W    = $clog2(N_DIGITS) + 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N_DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    HEX,
`ifdef RESP_WRITE_ACK_EN
    OK_O,
    OK_K,
`endif
    NL
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  data_shift;
  logic [CNT_W-1:0]   digit_cnt;
  logic               handshake;
  logic               completion;
  logic               read_done;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  always_comb begin
    data_shift = data_q << 4;
    handshake  = M_axis_tvalid & M_axis_tready;
    read_done  = Cs & Ack & ~We;
    // Writes only count as completions when the write reply path exists.
`ifdef RESP_WRITE_ACK_EN
    completion = Cs & Ack;
`else
    completion = read_done;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= IDLE;
      M_axis_tvalid <= 1'b0;
      M_axis_tdata  <= 8'h00;
      Busy          <= 1'b0;
      Overrun       <= 1'b0;
      data_q        <= '0;
      digit_cnt     <= '0;
    end else begin
      // Busy is still high during the NL handshake, so a completion there is dropped.
      if (completion && Busy)
        Overrun <= 1'b1;
      else if (Overrun_clr)
        Overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (read_done) begin
            state         <= HEX;
            data_q        <= Rdata;
            digit_cnt     <= '0;
            M_axis_tvalid <= 1'b1;
            M_axis_tdata  <= hex_ascii(Rdata[DATA_W-1 -: 4]);
            Busy          <= 1'b1;
          end
`ifdef RESP_WRITE_ACK_EN
          else if (Cs && Ack && We) begin
            state         <= OK_O;
            M_axis_tvalid <= 1'b1;
            M_axis_tdata  <= 8'h4F;
            Busy          <= 1'b1;
          end
`endif
        end

        HEX: begin
          if (handshake) begin
            digit_cnt <= digit_cnt + CNT_W'(1);
            if (digit_cnt == LAST_DIGIT) begin
              state        <= NL;
              M_axis_tdata <= NL_CHAR;
            end else begin
              data_q       <= data_shift;
              M_axis_tdata <= hex_ascii(data_shift[DATA_W-1 -: 4]);
            end
          end
        end

`ifdef RESP_WRITE_ACK_EN
        OK_O: begin
          if (handshake) begin
            state        <= OK_K;
            M_axis_tdata <= 8'h4B;
          end
        end

        OK_K: begin
          if (handshake) begin
            state        <= NL;
            M_axis_tdata <= NL_CHAR;
          end
        end
`endif

        NL: begin
          if (handshake) begin
            state         <= IDLE;
            M_axis_tvalid <= 1'b0;
            M_axis_tdata  <= 8'h00;
            Busy          <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          M_axis_tvalid <= 1'b0;
          Busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_response_encoder.sv
// Randomized and directed stimulus for response_encoder, checked against a byte-queue reply model.
module tb_response_encoder;

  logic        Clk;
  logic        Rst;
  logic        Cs;
  logic        We;
  logic        Ack;
  logic [31:0] Rdata;
  logic        M_axis_tvalid;
  logic [7:0]  M_axis_tdata;
  logic        M_axis_tready;
  logic        Busy;
  logic        Overrun;
  logic        Overrun_clr;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;

`ifdef RESP_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  response_encoder #(.DATA_W(32), .NL_CHAR(8'h0A)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Cs           (Cs),
    .We           (We),
    .Ack          (Ack),
    .Rdata        (Rdata),
    .M_axis_tvalid(M_axis_tvalid),
    .M_axis_tdata (M_axis_tdata),
    .M_axis_tready(M_axis_tready),
    .Busy         (Busy),
    .Overrun      (Overrun),
    .Overrun_clr  (Overrun_clr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A reply is simply the list of bytes the line should carry.
  task automatic push_read(input logic [31:0] rd);
    logic [3:0] n;
    for (int i = 7; i >= 0; i--) begin
      n = rd[4*i +: 4];
      exp_q.push_back(n < 10 ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10);
    end
    exp_q.push_back(8'h0A);
  endtask

  task automatic cyc(input logic cs_i, input logic we_i, input logic ack_i, input logic [31:0] rd_i,
                     input logic rdy_i, input logic clr_i, input logic rst_i);
    bit busy_m, hs, counted;
    Cs = cs_i; We = we_i; Ack = ack_i; Rdata = rd_i;
    M_axis_tready = rdy_i; Overrun_clr = clr_i; Rst = rst_i;
    @(posedge Clk);
    if (rst_i) begin
      exp_q.delete();
      exp_ovr = 1'b0;
    end else begin
      busy_m  = exp_q.size() != 0;
      hs      = busy_m && rdy_i;
      counted = cs_i && ack_i && (!we_i || WACK);
      if (counted && busy_m) exp_ovr = 1'b1;
      else if (clr_i)        exp_ovr = 1'b0;
      if (hs) void'(exp_q.pop_front());
      if (counted && !busy_m) begin
        if (!we_i) push_read(rd_i);
        else begin
          exp_q.push_back(8'h4F);
          exp_q.push_back(8'h4B);
          exp_q.push_back(8'h0A);
        end
      end
    end
    @(negedge Clk);
    check("tvalid", 32'(M_axis_tvalid), 32'(exp_q.size() != 0));
    check("busy", 32'(Busy), 32'(exp_q.size() != 0));
    check("overrun", 32'(Overrun), 32'(exp_ovr));
    if (exp_q.size() != 0) check("tdata", 32'(M_axis_tdata), 32'(exp_q[0]));
  endtask

  task automatic idle(input int n, input logic rdy_i);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, rdy_i, 0, 0);
  endtask

  initial begin
    Rst = 1'b1; Cs = 0; We = 0; Ack = 0; Rdata = '0; M_axis_tready = 0; Overrun_clr = 0;
    @(negedge Clk);
    cyc(0, 0, 0, 32'h0, 0, 0, 1);
    cyc(0, 0, 0, 32'h0, 0, 0, 1);
    check("reset_tdata", 32'(M_axis_tdata), 32'h0);

    // DEADBEEF at full rate
    cyc(1, 0, 1, 32'hDEADBEEF, 1, 0, 0);
    idle(12, 1);

    // 0123abcd with tready toggling
    cyc(1, 0, 1, 32'h0123abcd, 0, 0, 0);
    for (int i = 0; i < 24; i++) cyc(0, 0, 0, 32'h0, logic'(i % 2), 0, 0);
    idle(3, 1);

    // write acknowledge
    cyc(1, 1, 1, 32'hFFFF_FFFF, 1, 0, 0);
    idle(6, 1);

    // second read during the 3rd digit, then clear
    cyc(1, 0, 1, 32'h89ABCDEF, 1, 0, 0);
    cyc(0, 0, 0, 32'h0, 1, 0, 0);
    cyc(0, 0, 0, 32'h0, 1, 0, 0);
    cyc(1, 0, 1, 32'h11111111, 1, 0, 0);
    idle(10, 1);
    cyc(0, 0, 0, 32'h0, 1, 1, 0);
    idle(2, 1);

    // reset after 4 bytes, then an all-zero read
    cyc(1, 0, 1, 32'hCAFEF00D, 1, 0, 0);
    idle(4, 1);
    cyc(0, 0, 0, 32'h0, 1, 0, 1);
    cyc(1, 0, 1, 32'h00000000, 1, 0, 0);
    idle(12, 1);

    // read arriving with the NL handshake
    cyc(1, 0, 1, 32'h76543210, 1, 0, 0);
    idle(8, 1);
    cyc(1, 0, 1, 32'hAAAAAAAA, 1, 0, 0);
    idle(4, 1);
    cyc(0, 0, 0, 32'h0, 1, 1, 0);

    // set and clear together keeps Overrun high
    cyc(1, 0, 1, 32'h5A5A5A5A, 1, 0, 0);
    cyc(1, 0, 1, 32'h0, 1, 1, 0);
    idle(12, 1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic cs_r, ack_r;
      cs_r  = ($urandom_range(0, 3) != 0);
      ack_r = ($urandom_range(0, 5) == 0);
      cyc(cs_r, logic'($urandom_range(0, 1)), ack_r, $urandom,
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 299) == 0));
    end
    idle(12, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
